// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares a single-port combinational program ROM between
// the instruction-fetch port and a data-side constant-load port.
// Each granted access is range/alignment checked, spends one cycle in READ
// driving the ROM, and returns registered data with a one-cycle valid pulse.
// Optional feature macro: ROM_ARB_ROUND_ROBIN_EN
//   defined   -> ties go to the port not granted most recently
//   undefined -> fixed priority, fetch wins every tie
module rom_access_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic                  Clk_i,
  input  logic                  Reset_n_i,
  // instruction-fetch port
  input  logic                  Fetch_Req_i,
  input  logic [ADDR_WIDTH-1:0] Fetch_Addr_i,
  output logic                  Fetch_Gnt_o,
  output logic                  Fetch_Valid_o,
  output logic [DATA_WIDTH-1:0] Fetch_Data_o,
  output logic                  Fetch_Err_o,
  // data-side read port
  input  logic                  Data_Req_i,
  input  logic [ADDR_WIDTH-1:0] Data_Addr_i,
  output logic                  Data_Gnt_o,
  output logic                  Data_Valid_o,
  output logic [DATA_WIDTH-1:0] Data_Rdata_o,
  output logic                  Data_Err_o,
  // ROM pins
  output logic                  Rom_Enable_o,
  output logic [ADDR_WIDTH-1:0] Rom_Address_o,
  input  logic [DATA_WIDTH-1:0] Rom_Instruction_i
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP
  } state_e;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } req_e;

  // FSM and transaction context
  state_e                  state_q, state_d;
  req_e                    id_q, id_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;

  // per-port response registers
  logic                    fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_d;
  logic                    fetch_err_q, fetch_err_d;
  logic                    data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;
  logic                    data_err_q, data_err_d;

  // arbitration
  logic                    grant_ok;
  logic                    fetch_pick;
  logic                    fetch_gnt;
  logic                    data_gnt;
  logic                    any_gnt;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   rsp_word;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  // 1: data port was granted most recently, so fetch wins the next tie
  logic                    last_data_q, last_data_d;
`endif

  // Decide which requester (if any) is granted this cycle
  always_comb begin
    grant_ok = (state_q == ST_IDLE) || (state_q == ST_RESP);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    fetch_pick = Fetch_Req_i && (!Data_Req_i || last_data_q);
`else
    fetch_pick = Fetch_Req_i;
`endif
    fetch_gnt = grant_ok && fetch_pick;
    data_gnt  = grant_ok && Data_Req_i && !fetch_pick;
    any_gnt   = fetch_gnt || data_gnt;
  end

  // Select the winner's address and classify it as legal or erroneous
  always_comb begin
    sel_addr = fetch_gnt ? Fetch_Addr_i : Data_Addr_i;
    sel_idx  = sel_addr[ADDR_WIDTH-1:2];
    sel_err  = (sel_addr[1:0] != 2'b00) || (sel_idx >= DEPTH_IDX);
  end

`ifdef ROM_ARB_ROUND_ROBIN_EN
  // Track the most recent winner for round-robin tie breaking
  always_comb begin
    last_data_d = last_data_q;
    if (any_gnt) begin
      last_data_d = data_gnt;
    end
  end
`endif

  // Next-state logic and latching of the granted transaction
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    err_d      = err_q;
    rom_addr_d = rom_addr_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (any_gnt) begin
          state_d = ST_READ;
          id_d    = data_gnt ? REQ_DATA : REQ_FETCH;
          err_d   = sel_err;
          // ROM address only moves for legal accesses so it holds otherwise
          if (!sel_err) begin
            rom_addr_d = {2'b00, sel_idx};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the ROM word (or zero on error) into the owning port's registers
  always_comb begin
    rsp_word      = err_q ? '0 : Rom_Instruction_i;
    fetch_valid_d = (state_q == ST_READ) && (id_q == REQ_FETCH);
    data_valid_d  = (state_q == ST_READ) && (id_q == REQ_DATA);
    fetch_data_d  = fetch_data_q;
    fetch_err_d   = fetch_err_q;
    data_rdata_d  = data_rdata_q;
    data_err_d    = data_err_q;
    if (fetch_valid_d) begin
      fetch_data_d = rsp_word;
      fetch_err_d  = err_q;
    end
    if (data_valid_d) begin
      data_rdata_d = rsp_word;
      data_err_d   = err_q;
    end
  end

  // State and transaction registers; async reset drops any pending response
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q    <= ST_IDLE;
      id_q       <= REQ_FETCH;
      err_q      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      err_q      <= err_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Response registers for both ports
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= '0;
      data_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_err_q   <= fetch_err_d;
      data_valid_q  <= data_valid_d;
      data_rdata_q  <= data_rdata_d;
      data_err_q    <= data_err_d;
    end
  end

`ifdef ROM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer; resets to "data last" so fetch wins the first tie
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`endif

  assign Fetch_Gnt_o   = fetch_gnt;
  assign Data_Gnt_o    = data_gnt;
  assign Fetch_Valid_o = fetch_valid_q;
  assign Fetch_Data_o  = fetch_data_q;
  assign Fetch_Err_o   = fetch_err_q;
  assign Data_Valid_o  = data_valid_q;
  assign Data_Rdata_o  = data_rdata_q;
  assign Data_Err_o    = data_err_q;
  assign Rom_Enable_o  = (state_q == ST_READ) && !err_q;
  assign Rom_Address_o = rom_addr_q;

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Controller that shares the single-port program ROM (combinational read, enable-gated, word-indexed) between two requesters: the instruction-fetch stage and a data-side read port for constant loads. It arbitrates requests, converts byte addresses to word indices, range- and alignment-checks them, drives the ROM's enable/address pins, and returns registered read data with a one-cycle valid pulse. It sits between the core pipeline and the ROM in the memory system.

## Interface
- DATA_WIDTH, 32, ROM word width and read-data width
- ADDR_WIDTH, 32, byte-address width of both requester ports
- MEMORY_DEPTH, 64, number of ROM words; legal word indices are 0..MEMORY_DEPTH-1

- Clk_i  in  1  single clock, all state on rising edge
- Reset_n_i  in  1  asynchronous, active-low reset
- Fetch_Req_i  in  1  fetch request; held with address until granted
- Fetch_Addr_i  in  ADDR_WIDTH  fetch byte address
- Fetch_Gnt_o  out  1  combinational; request accepted this cycle
- Fetch_Valid_o  out  1  one-cycle pulse; Fetch_Data_o/Fetch_Err_o valid
- Fetch_Data_o  out  DATA_WIDTH  fetched word
- Fetch_Err_o  out  1  misaligned or out-of-range address
- Data_Req_i, Data_Addr_i, Data_Gnt_o, Data_Valid_o, Data_Rdata_o, Data_Err_o  same widths/semantics for the data port
- Rom_Enable_o  out  1  ROM enable
- Rom_Address_o  out  ADDR_WIDTH  ROM word index, zero-extended
- Rom_Instruction_i  in  DATA_WIDTH  ROM read data

## Operation
- FSM states: IDLE, READ, RESP. Reset → IDLE.
- Grants are issued only in IDLE or RESP, at most one per cycle; a grant latches the winner's address and requester ID, then moves to READ. With no grant: IDLE stays IDLE, RESP goes to IDLE.
- Address check at grant: word index = Addr[ADDR_WIDTH-1:2]. The access is an error if Addr[1:0] != 0 or the index >= MEMORY_DEPTH.
- READ (always exactly one cycle, then RESP):
  - Legal access: Rom_Enable_o=1 and Rom_Address_o=index; Rom_Instruction_i is captured into the response register at the end of the cycle.
  - Error access: Rom_Enable_o=0 and the response register loads 0.
- RESP: the latched requester's Valid_o=1 for exactly one cycle, with Data and Err stable alongside it. The other requester's Valid_o=0.
- Data/Err outputs hold their last value until the next response to that same port.
- Rom_Address_o holds its last value outside READ. Rom_Enable_o=0 outside READ.
- Simultaneous requests are resolved by the arbitration policy (see Configuration).
- A request asserted during READ waits; it is granted in RESP at the earliest.
- Reset asserted mid-transaction: FSM → IDLE immediately, the pending response is dropped (no Valid), and all outputs return to reset values.
- Reset values: all Gnt/Valid/Err = 0, Fetch_Data_o = Data_Rdata_o = 0, Rom_Enable_o = 0, Rom_Address_o = 0, round-robin pointer = "data last".

## Timing
- Grant in cycle N → Rom_Enable_o high in N+1 → Valid_o high in N+2.
- Back-to-back throughput: one access per 2 cycles (a grant in RESP overlaps the response).
- Gnt_o depends combinationally on Req_i and state. Valid/Data/Err/Rom_* are registered, except Rom_Enable_o, which is decoded from state and the latched error flag.
- Requester holds Req_i and Addr_i stable until the cycle Gnt_o=1. It deasserts or presents a new request in the following cycle.

## Configuration
- ROM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted most recently. The pointer updates on every grant. After reset, fetch wins the first tie.
- Undefined: fixed priority, fetch always wins ties. The data port may starve under continuous fetch requests; this is accepted.

## Test plan
- Reset then Fetch_Req_i=1, Addr=0x8 → Fetch_Gnt_o in cycle 0, Rom_Enable_o=1 with Rom_Address_o=2 in cycle 1, Fetch_Valid_o in cycle 2 with Fetch_Data_o=rom[2], Fetch_Err_o=0.
- Both ports request continuously (Fetch 0x0, Data 0x4), macro defined → grants alternate fetch, data, fetch… every 2 cycles; the data port returns rom[1]. Macro undefined → only fetch is granted.
- Data_Addr=0x6 (misaligned) and Data_Addr=4*MEMORY_DEPTH (out of range) → Data_Valid_o=1, Data_Err_o=1, Data_Rdata_o=0, Rom_Enable_o stays 0.
- Request arrives during READ → no grant in READ; granted in RESP; its Valid follows 2 cycles later.
- Reset_n_i pulsed low during READ → no Valid pulse; all outputs 0; the next fetch completes normally with 2-cycle latency.
